// File: rtl/usb_in_stream_arbiter_if.sv
// Handshake bundle between the IN-stream arbiter, its byte-stream source FIFOs,
// the FX2-side destination FIFO and the slave-FIFO controller's flush handshake.
interface usb_in_stream_arbiter_if #(
  parameter int NUM_SRC = 2
);
  logic [NUM_SRC-1:0]   src_enable;
  logic [NUM_SRC-1:0]   src_empty;
  logic [8*NUM_SRC-1:0] src_data;
  logic [NUM_SRC-1:0]   src_pop;
  logic                 dst_full;
  logic                 dst_push;
  logic [7:0]           dst_data;
  logic                 flush_req;
  logic                 flush_ack;
  logic [3:0]           grant_id;
  logic                 busy;

  modport master (
    input  src_enable, src_empty, src_data, dst_full, flush_ack,
    output src_pop, dst_push, dst_data, flush_req, grant_id, busy
  );

  modport slave (
    output src_enable, src_empty, src_data, dst_full, flush_ack,
    input  src_pop, dst_push, dst_data, flush_req, grant_id, busy
  );
endinterface

// File: rtl/usb_in_stream_arbiter.sv
// Round-robin arbiter sharing the FX2 IN byte path between NUM_SRC source FIFOs:
// header-prefixed bursts through a 2-entry skid buffer, plus idle-timeout flush request.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | no grant; pick next eligible source or run the idle timeout
// ST_HDR   | push header byte {4'hA, grant_id}
// ST_DATA  | pop granted source and forward bytes through the skid buffer
// ST_DRAIN | no more pops; wait for in-flight byte and skid buffer to empty
// ST_FLUSH | flush_req held until flush_ack
module usb_in_stream_arbiter #(
  parameter int NUM_SRC   = 2,
  parameter int MAX_BURST = 64,
  parameter int TIMEOUT   = 1024
) (
  input  logic                   clk,
  input  logic                   reset_n,
  usb_in_stream_arbiter_if.master bus
);
  localparam int PTR_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int IDLE_W = $clog2(TIMEOUT) + 1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HDR   = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_FLUSH = 3'd4;

  logic [2:0]         state, state_nxt;
  logic [PTR_W-1:0]   rr_ptr, rr_pick, rr_ptr_nxt;
  logic               rr_found;
  logic [3:0]         grant_id;
  logic [7:0]         burst_cnt;
  logic [IDLE_W-1:0]  idle_cnt;
  logic               dirty;
  logic               pend;
  logic [7:0]         skid_mem [2];
  logic               skid_wr, skid_rd;
  logic [1:0]         skid_occ;
  logic [NUM_SRC-1:0] eligible;
  logic               grant_elig;
  logic [7:0]         grant_byte;
  logic               hdr_push, data_push, dst_push;
  logic               burst_open, skid_room, pop_now, flush_done;

  assign eligible = bus.src_enable & ~bus.src_empty;

  always_comb begin
    grant_elig = 1'b0;
    grant_byte = 8'h00;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_id == 4'(i)) begin
        grant_elig = eligible[i];
        grant_byte = bus.src_data[8*i +: 8];
      end
    end
  end

  // First eligible source at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    idx      = 0;
    rr_found = 1'b0;
    rr_pick  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!rr_found && eligible[idx]) begin
        rr_found = 1'b1;
        rr_pick  = PTR_W'(idx);
      end
    end
  end

  assign rr_ptr_nxt = (int'(rr_pick) == NUM_SRC - 1) ? '0 : rr_pick + PTR_W'(1);

  assign hdr_push   = (state == ST_HDR) && !bus.dst_full;
  assign data_push  = ((state == ST_DATA) || (state == ST_DRAIN)) &&
                      (skid_occ != 2'd0) && !bus.dst_full;
  assign dst_push   = hdr_push || data_push;
  assign burst_open = grant_elig && (burst_cnt < 8'(MAX_BURST));
  // Occupancy after this cycle's landing byte and push must leave room for a new pop.
  assign skid_room  = (skid_occ + {1'b0, pend} - {1'b0, data_push}) < 2'd2;
  assign pop_now    = (state == ST_DATA) && burst_open && skid_room;
  assign flush_done = (state == ST_FLUSH) && bus.flush_ack;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (rr_found)
          state_nxt = ST_HDR;
        else if (dirty && (idle_cnt == IDLE_W'(TIMEOUT - 1)))
          state_nxt = ST_FLUSH;
      end
      ST_HDR:   if (!bus.dst_full) state_nxt = ST_DATA;
      ST_DATA:  if (!burst_open) state_nxt = ST_DRAIN;
      ST_DRAIN: if (!pend && (skid_occ == 2'd0)) state_nxt = ST_IDLE;
      ST_FLUSH: if (bus.flush_ack) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      grant_id  <= 4'd0;
      burst_cnt <= 8'd0;
      idle_cnt  <= '0;
      dirty     <= 1'b0;
      pend      <= 1'b0;
      skid_wr   <= 1'b0;
      skid_rd   <= 1'b0;
      skid_occ  <= 2'd0;
    end else begin
      state <= state_nxt;
      pend  <= pop_now;

      if ((state == ST_IDLE) && rr_found) begin
        grant_id <= 4'(rr_pick);
        rr_ptr   <= rr_ptr_nxt;
      end

      if (hdr_push)
        burst_cnt <= 8'd0;
      else if (pop_now)
        burst_cnt <= burst_cnt + 8'd1;

      if (pend) skid_wr <= ~skid_wr;
      if (data_push) skid_rd <= ~skid_rd;
      skid_occ <= skid_occ + {1'b0, pend} - {1'b0, data_push};

      if (flush_done)
        dirty <= 1'b0;
      else if (data_push)
        dirty <= 1'b1;

      if (dst_push || flush_done)
        idle_cnt <= '0;
      else if ((state == ST_IDLE) && dirty && (state_nxt == ST_IDLE))
        idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end

  // Byte popped last cycle is on src_data now.
  always_ff @(posedge clk) begin
    if (pend) skid_mem[skid_wr] <= grant_byte;
  end

  assign bus.src_pop   = pop_now ? (NUM_SRC'(1) << grant_id) : '0;
  assign bus.dst_push  = dst_push;
  assign bus.dst_data  = hdr_push  ? {4'hA, grant_id} :
                         data_push ? skid_mem[skid_rd] : 8'h00;
  assign bus.flush_req = (state == ST_FLUSH);
  assign bus.grant_id  = grant_id;
  assign bus.busy      = (state != ST_IDLE);
endmodule

// File: tb/tb_usb_in_stream_arbiter.sv
// Randomized bench for usb_in_stream_arbiter: source FIFO models, dst stream capture,
// and a queue-based model of the expected header/data byte stream.
module tb_usb_in_stream_arbiter;
  localparam int NS = 2;
  localparam int MB = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  usb_in_stream_arbiter_if #(.NUM_SRC(NS)) bus ();

  usb_in_stream_arbiter #(.NUM_SRC(NS), .MAX_BURST(MB), .TIMEOUT(TO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Source FIFOs, standard mode: Q valid the cycle after RdEn.
  logic [7:0] mem [NS][256];
  int wr_idx [NS];
  int rd_idx [NS];
  int pop_cnt [NS];

  always_comb begin
    for (int i = 0; i < NS; i++) bus.src_empty[i] = (rd_idx[i] == wr_idx[i]);
  end

  always @(posedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (bus.src_pop[i] && (rd_idx[i] < wr_idx[i])) begin
        bus.src_data[8*i +: 8] <= mem[i][rd_idx[i] % 256];
        rd_idx[i]  <= rd_idx[i] + 1;
        pop_cnt[i] <= pop_cnt[i] + 1;
      end
    end
  end

  // dst_full: 0 = never, 1 = random, 2 = forced
  int full_mode = 0;
  always @(posedge clk) begin
    #1;
    case (full_mode)
      0:       bus.dst_full = 1'b0;
      1:       bus.dst_full = ($urandom_range(0, 2) == 0);
      default: bus.dst_full = 1'b1;
    endcase
  end

  logic auto_ack = 1'b1;
  int ack_token = 0;
  int ack_seen = 0;
  always @(posedge clk) begin
    #1;
    if (ack_token != ack_seen) begin
      bus.flush_ack = 1'b1;
      ack_seen = ack_token;
    end else begin
      bus.flush_ack = auto_ack && bus.flush_req && !bus.flush_ack;
    end
  end

  logic [7:0] got_q [$];
  int cyc = 0;
  int last_push_cyc = 0;
  int flush_rise_cyc = -1;
  logic flush_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (bus.dst_push) begin
      got_q.push_back(bus.dst_data);
      last_push_cyc = cyc;
      chk("push_while_full", int'(bus.dst_full), 0);
    end
    for (int i = 0; i < NS; i++)
      if (bus.src_pop[i]) chk("pop_while_empty", int'(bus.src_empty[i]), 0);
    if (bus.flush_req && !flush_prev) flush_rise_cyc = cyc;
    flush_prev = bus.flush_req;
  end

  // Reference model: pending bytes per source and the round-robin pointer.
  logic [7:0] mdl_q [NS][$];
  int mdl_ptr = 0;
  logic [7:0] exp_q [$];
  int got_base = 0;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_byte(input int s, input logic [7:0] b);
    mem[s][wr_idx[s] % 256] = b;
    wr_idx[s]++;
    mdl_q[s].push_back(b);
  endtask

  task automatic load(input int s, input int n);
    for (int k = 0; k < n; k++) push_byte(s, 8'($urandom_range(0, 255)));
  endtask

  // Sources are fully loaded up front, so every burst is min(MB, bytes left).
  task automatic append_model();
    int pick;
    while (1) begin
      pick = -1;
      for (int k = 0; k < NS; k++) begin
        int idx = (mdl_ptr + k) % NS;
        if (pick < 0 && bus.src_enable[idx] && mdl_q[idx].size() > 0) pick = idx;
      end
      if (pick < 0) break;
      exp_q.push_back(8'hA0 | 8'(pick));
      for (int n = 0; n < MB && mdl_q[pick].size() > 0; n++)
        exp_q.push_back(mdl_q[pick].pop_front());
      mdl_ptr = (pick + 1) % NS;
    end
  endtask

  task automatic expect_start();
    got_base = got_q.size();
    exp_q.delete();
    append_model();
  endtask

  task automatic expect_finish(input string tag, input int budget);
    int n = 0;
    int got_n;
    while (((got_q.size() - got_base) < exp_q.size() || bus.busy) && n < budget) begin
      tick();
      n++;
    end
    got_n = got_q.size() - got_base;
    chk({tag, "_len"}, got_n, exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_n; k++)
      chk($sformatf("%s_byte%0d", tag, k), int'(got_q[got_base + k]), int'(exp_q[k]));
    chk({tag, "_idle"}, int'(bus.busy), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_src_pop"},   int'(bus.src_pop), 0);
    chk({tag, "_dst_push"},  int'(bus.dst_push), 0);
    chk({tag, "_dst_data"},  int'(bus.dst_data), 0);
    chk({tag, "_flush_req"}, int'(bus.flush_req), 0);
    chk({tag, "_grant_id"},  int'(bus.grant_id), 0);
    chk({tag, "_busy"},      int'(bus.busy), 0);
  endtask

  // Reset discards in-flight bytes; the model restarts from what is left in the FIFOs.
  task automatic do_reset(input string tag);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    tick();
    tick();
    for (int s = 0; s < NS; s++) begin
      mdl_q[s].delete();
      for (int j = rd_idx[s]; j < wr_idx[s]; j++) mdl_q[s].push_back(mem[s][j % 256]);
    end
    mdl_ptr = 0;
    reset_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int p0, s0, k, n, viol, delay;

    bus.src_enable = '0;
    repeat (2) @(posedge clk);
    #3;
    check_reset_outputs("rst");
    tick();
    reset_n = 1'b1;
    tick();

    // single short burst
    bus.src_enable = 2'b11;
    p0 = pop_cnt[0];
    push_byte(0, 8'h11);
    push_byte(0, 8'h22);
    push_byte(0, 8'h33);
    expect_start();
    expect_finish("t1", 100);
    chk("t1_pops", pop_cnt[0] - p0, 3);

    // strict alternation between two loaded sources
    do_reset("t2_rst");
    load(0, 8);
    load(1, 8);
    expect_start();
    expect_finish("t2", 200);

    // destination stalls mid-burst
    load(0, 6);
    expect_start();
    n = 0;
    while ((got_q.size() - got_base) < 2 && n < 50) begin tick(); n++; end
    full_mode = 2;
    repeat (5) tick();
    full_mode = 0;
    expect_finish("t3", 200);

    // randomized loads, enables and backpressure
    full_mode = 1;
    for (int r = 0; r < 8; r++) begin
      bus.src_enable = 2'($urandom_range(1, 3));
      load(0, $urandom_range(0, 9));
      load(1, $urandom_range(0, 9));
      expect_start();
      expect_finish($sformatf("rnd%0d", r), 600);
    end
    bus.src_enable = 2'b11;
    expect_start();
    expect_finish("rnd_drain", 600);
    full_mode = 0;

    // idle timeout flush
    auto_ack = 1'b0;
    load(0, 2);
    expect_start();
    expect_finish("t5_burst", 100);
    ack_token++;  // stray ack outside FLUSH
    n = 0;
    while (!bus.flush_req && n < 60) begin tick(); n++; end
    delay = -1;
    if (bus.flush_req) begin
      @(negedge clk);
      #1;
      delay = flush_rise_cyc - last_push_cyc;
    end
    chk($sformatf("t5_flush_delay_%0d_in_16_to_19", delay), int'(delay >= TO && delay <= TO + 3), 1);
    load(0, 3);
    expect_start();
    viol = 0;
    repeat (8) begin
      tick();
      if (bus.dst_push || (bus.src_pop != '0) || !bus.flush_req) viol++;
    end
    chk("t5_flush_hold_viol", viol, 0);
    ack_token++;
    tick();
    chk("t5_flush_req_before_ack", int'(bus.flush_req), 1);
    tick();
    chk("t5_flush_req_after_ack", int'(bus.flush_req), 0);
    expect_finish("t5_after_ack", 100);
    auto_ack = 1'b1;

    // reset mid-burst; next grant restarts at src0
    load(0, 8);
    load(1, 4);
    got_base = got_q.size();
    n = 0;
    while ((got_q.size() - got_base) < 3 && n < 80) begin tick(); n++; end
    chk("t6_reached_data", int'(bus.busy), 1);
    do_reset("t6_rst");
    expect_start();
    expect_finish("t6", 300);

    // src_enable[0] drops mid-burst
    do_reset("t7_rst");
    s0 = pop_cnt[0];
    load(0, 8);
    load(1, 3);
    bus.src_enable = 2'b11;
    got_base = got_q.size();
    n = 0;
    while ((got_q.size() - got_base) < 2 && n < 50) begin tick(); n++; end
    bus.src_enable = 2'b10;
    k = pop_cnt[0] - s0;
    exp_q.delete();
    exp_q.push_back(8'hA0);
    for (int j = 0; j < k && mdl_q[0].size() > 0; j++) exp_q.push_back(mdl_q[0].pop_front());
    mdl_ptr = 1;
    append_model();
    expect_finish("t7", 200);
    chk("t7_src0_no_pop_when_disabled", pop_cnt[0] - s0, k);
    bus.src_enable = 2'b11;
    expect_start();
    expect_finish("t7_rest", 200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
